// File: rtl/pulse_hs_buffer_if.sv
// pulse_hs_buffer_if: groups the capture strobe, payload and downstream valid/ready
// handshake of pulse_hs_buffer together with its occupancy and drop status.
//
// Modports
//   master : the buffer itself. It drives out_valid, dout, full, empty, level and drop_pulse.
//            It samples in_pulse, din and out_ready.
//   slave  : the surrounding logic (producer plus consumer). It drives in_pulse, din and
//            out_ready, and observes the rest.
//
// Parameters must match the ones given to the pulse_hs_buffer instance.
interface pulse_hs_buffer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned LvlW = $clog2(DEPTH) + 1;

  logic              in_pulse;
  logic [DATA_W-1:0] din;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic [LvlW-1:0]   level;
  logic              drop_pulse;

  modport master (
    input  in_pulse,
    input  din,
    input  out_ready,
    output out_valid,
    output dout,
    output full,
    output empty,
    output level,
    output drop_pulse
  );

  modport slave (
    output in_pulse,
    output din,
    output out_ready,
    input  out_valid,
    input  dout,
    input  full,
    input  empty,
    input  level,
    input  drop_pulse
  );
endinterface

// File: rtl/pulse_hs_buffer.sv
// pulse_hs_buffer: captures a DATA_W-bit word on every one-cycle in_pulse into a DEPTH-entry
// circular queue. The queued words are offered to a downstream consumer through a
// valid/ready handshake. A pulse that arrives while the queue is full, with no pop in the
// same cycle, is discarded. The discard is flagged on drop_pulse for one cycle.
//
// Ports
//   clk_i      : sole clock, rising edge
//   rst_i      : asynchronous reset, active-high; clears pointers, memory and flags
//   bus        : pulse_hs_buffer_if.master carrying the following signals
//                in_pulse/din  - capture strobe and payload
//                out_valid/out_ready/dout - head-of-queue handshake
//                full/empty/level - occupancy derived from the registered pointers
//                drop_pulse    - registered one-cycle discard flag
//   ovf_clr    : clears ovf_cnt on the next edge; present only with PULSE_HS_OVF_CNT_EN
//   ovf_cnt    : saturating 8-bit drop count; present only with PULSE_HS_OVF_CNT_EN
//
// Optional feature macro: PULSE_HS_OVF_CNT_EN enables the overflow counter and its ports.
module pulse_hs_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  pulse_hs_buffer_if.master        bus
`ifdef PULSE_HS_OVF_CNT_EN
  ,
  input  logic                     ovf_clr,
  output logic [7:0]               ovf_cnt
`endif
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [AddrW:0]    wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] hold_q;
  logic              drop_q;

  logic              full, empty;
  logic              push, pop, drop;
  logic [DATA_W-1:0] head;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
            (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
    head  = mem_q[rd_ptr_q[AddrW-1:0]];
    pop   = !empty && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    push  = bus.in_pulse && (!full || pop);
    drop  = bus.in_pulse && full && !pop;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= bus.din;
    end
  end

  // Remember the last word handed over so dout stays put once the queue drains.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q <= '0;
    end else if (pop) begin
      hold_q <= head;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop;
    end
  end

`ifdef PULSE_HS_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  // Clear takes priority over a drop in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_cnt_q <= '0;
    end else if (ovf_clr) begin
      ovf_cnt_q <= '0;
    end else if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign bus.out_valid  = !empty;
  assign bus.dout       = empty ? hold_q : head;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.level      = wr_ptr_q - rd_ptr_q;
  assign bus.drop_pulse = drop_q;

endmodule

// File: doc/pulse_hs_buffer.md
# pulse_hs_buffer

Single-clock buffer that captures a DATA_W-bit word on every one-cycle `in_pulse` and presents the queued words to a downstream consumer through a valid/ready handshake. It replaces the one-word-in-flight pulse/request scheme with a parametrised DEPTH-entry queue, so back-to-back pulses are no longer lost while the consumer is busy. Overflow is reported explicitly. The block sits on the producer side of a handshake link, in front of any consumer that cannot accept data on every cycle.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- DEPTH, 4, queue entries; power of two, ≥2
- clk_i  input  1  sole clock, rising edge
- rst_i  input  1  asynchronous reset, active-high
- in_pulse  input  1  one-cycle capture strobe
- din  input  DATA_W  payload sampled when in_pulse=1
- out_valid  output  1  head word available on dout
- out_ready  input  1  consumer accepts head word this cycle
- dout  output  DATA_W  head-of-queue word
- full  output  1  DEPTH words held
- empty  output  1  no words held
- level  output  $clog2(DEPTH)+1  words held, 0..DEPTH
- drop_pulse  output  1  one-cycle flag: a pulse was discarded
- ovf_clr  input  1  clears ovf_cnt (present only with PULSE_HS_OVF_CNT_EN)
- ovf_cnt  output  8  saturating drop count (present only with PULSE_HS_OVF_CNT_EN)

## Operation
- Storage: circular array of DEPTH words, with wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - empty: pointers equal.
  - full: low bits equal, MSB differs.
  - level = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Push: in_pulse=1 and (!full or pop this cycle) → write din at wr_ptr, increment wr_ptr.
- Pop: out_valid & out_ready → increment rd_ptr.
- out_valid = !empty. dout = mem[rd_ptr] while out_valid; dout holds its last value while !out_valid.
- Handshake rules:
  - While out_valid=1 and out_ready=0, dout and out_valid are held stable.
  - out_ready while out_valid=0 has no effect.
- Drop: in_pulse=1, full=1 and no pop in the same cycle → din is discarded, and drop_pulse=1 for exactly the next cycle.
- Simultaneous push+pop:
  - When full, the push is accepted and level stays DEPTH.
  - When not empty, level is unchanged.
  - When empty, there is no pop (out_valid=0), so only the push takes effect.
- No bypass: a word pushed into an empty queue is first visible the cycle after capture.
- Pointer wrap-around is seamless; order is strictly FIFO.
- Reset (at any time, including mid-transfer) asynchronously discards all contents:
  - out_valid=0, dout=0, full=0, empty=1, level=0, drop_pulse=0, ovf_cnt=0.
  - The memory is cleared to 0.

## Timing
- Capture latency: in_pulse at edge k → out_valid=1 and dout=din(k) in the cycle after edge k (1 cycle).
- Throughput: one push and one pop per cycle sustained.
- full, empty, level and out_valid are registered-pointer derived and update on the edge after push/pop.
- drop_pulse is registered: high in cycle k+1 for a drop at edge k.
- Reset release: first push is accepted on the first rising edge with rst_i=0.

## Configuration
- PULSE_HS_OVF_CNT_EN defined:
  - ovf_clr and ovf_cnt ports exist.
  - ovf_cnt increments on every drop and saturates at 255.
  - ovf_clr=1 sets ovf_cnt to 0 on the next edge; if a drop occurs in the same cycle, clear wins and the count is 0.
  - Reset value of ovf_cnt is 0.
- PULSE_HS_OVF_CNT_EN undefined: ovf_clr and ovf_cnt and their counter logic are absent; drop_pulse is still generated.

## Test plan
- Single transfer (DATA_W=8, DEPTH=4): pulse din=0xA5, out_ready=1 → out_valid high one cycle later with dout=0xA5, then empty=1.
- Backpressure and order: 4 back-to-back pulses (0x01..0x04), out_ready=0 → full=1, level=4, dout stays 0x01; then out_ready=1 → 0x01..0x04 pop on 4 consecutive cycles.
- Overflow: with the queue full and out_ready=0, pulse din=0xFF → drop_pulse high for exactly 1 cycle, level=4, 0xFF never appears on dout; with the macro defined, ovf_cnt=1.
- Full with simultaneous push+pop: queue full, out_ready=1, pulse din=0x55 → no drop, level stays 4, 0x55 emerges fifth.
- Wrap-around: 10 push/pop pairs at DEPTH=4, values 0..9 → all received in order, pointers wrap without a false full or empty.
- Reset mid-operation: level=3, assert rst_i asynchronously → out_valid=0, level=0, dout=0, ovf_cnt=0 immediately; a push after release yields only the new word.
